// File: rtl/clk_divider_gen_if.sv
// Control and status bundle of the runtime-ratio clock divider.
interface clk_divider_gen_if #(
  parameter int RATIO_W = 8
);
  // Protocol: no valid/ready pair. clk_en and div_ratio are levels sampled on
  // every ref_clk posedge; div_tick and ratio_upd are single-cycle strobes
  // launched from a posedge and valid until the next one.
  logic               clk_en;
  logic [RATIO_W-1:0] div_ratio;
  logic               div_clk;
  logic               div_tick;
  logic               ratio_upd;
  logic [RATIO_W-1:0] active_ratio;

  modport master (
    output clk_en,
    output div_ratio,
    input  div_clk,
    input  div_tick,
    input  ratio_upd,
    input  active_ratio
  );

  modport slave (
    input  clk_en,
    input  div_ratio,
    output div_clk,
    output div_tick,
    output ratio_upd,
    output active_ratio
  );
endinterface

// File: rtl/clk_divider_gen.sv
// Integer clock divider with period-boundary ratio adoption and ref_clk bypass.
// Optional macro CLKDIV_DUTY50_EN: half-cycle duty correction for odd ratios.
module clk_divider_gen #(
  parameter int RATIO_W = 8
) (
  input logic              ref_clk,
  input logic              rst,
  clk_divider_gen_if.slave bus
);
  localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] TWO = RATIO_W'(2);

  logic               en_q;
  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] act_r;
  logic [RATIO_W-1:0] cnt_dec;
  logic [RATIO_W-1:0] high_cnt;
  logic [RATIO_W-1:0] low_cnt;
  logic               div_pos;
  logic               div_tick;
  logic               ratio_upd;
  logic               run;
  logic               div_out;

  assign run     = en_q && (act_r >= TWO);
  assign cnt_dec = cnt - ONE;

`ifdef CLKDIV_DUTY50_EN
  assign high_cnt = act_r >> 1;
`else
  // ceil(R/2) written without the R+1 that would overflow at the maximum ratio
  assign high_cnt = (act_r >> 1) + {{(RATIO_W-1){1'b0}}, act_r[0]};
`endif
  assign low_cnt = act_r - high_cnt;

  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      cnt       <= '0;
      div_pos   <= 1'b0;
      act_r     <= '0;
      div_tick  <= 1'b0;
      ratio_upd <= 1'b0;
    end else begin
      en_q <= bus.clk_en;
      if (!run) begin
        cnt       <= '0;
        div_pos   <= 1'b0;
        act_r     <= bus.div_ratio;
        div_tick  <= 1'b0;
        ratio_upd <= 1'b0;
      end else if (cnt == '0) begin
        // Period start: the only point where a new ratio is taken.
        cnt       <= bus.div_ratio - ONE;
        act_r     <= bus.div_ratio;
        div_pos   <= 1'b1;
        div_tick  <= 1'b1;
        ratio_upd <= (bus.div_ratio != act_r);
      end else begin
        cnt       <= cnt_dec;
        div_pos   <= (cnt_dec >= low_cnt);
        div_tick  <= 1'b0;
        ratio_upd <= 1'b0;
      end
    end
  end

`ifdef CLKDIV_DUTY50_EN
  logic neg_q;

  always_ff @(negedge ref_clk or negedge rst) begin
    if (!rst) neg_q <= 1'b0;
    else      neg_q <= div_pos;
  end

  // The half-cycle stretch only applies to odd ratios; even ratios keep exact halves.
  assign div_out = div_pos | (neg_q & act_r[0]);
`else
  assign div_out = div_pos;
`endif

  assign bus.div_clk      = run ? div_out : ref_clk;
  assign bus.div_tick     = div_tick;
  assign bus.ratio_upd    = ratio_upd;
  assign bus.active_ratio = act_r;
endmodule

// File: tb/tb_clk_divider_gen.sv
// Directed bench for clk_divider_gen: expected period records are queued by the
// driver and checked by a tick monitor that measures period and high half-cycles.
module tb_clk_divider_gen;
  localparam int W = 10;

  typedef struct packed {
    logic [W-1:0] ratio;
    logic         upd;
    logic [15:0]  gap;
    logic [15:0]  high;
  } exp_t;

  // clock / reset
  logic ref_clk = 1'b0;
  logic rst;

  always #5 ref_clk = ~ref_clk;

  clk_divider_gen_if #(.RATIO_W(W)) bus ();

  clk_divider_gen #(.RATIO_W(W)) dut (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // High time in half ref_clk periods for one divided period of ratio r.
  function automatic int exp_high(input int r);
`ifdef CLKDIV_DUTY50_EN
    return r;
`else
    return 2 * ((r + 1) / 2);
`endif
  endfunction

  // driver tasks
  task automatic push(input int r, input bit u, input int g, input int h);
    exp_t e;
    e.ratio = W'(r);
    e.upd   = u;
    e.gap   = 16'(g);
    e.high  = 16'(h);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ref_clk);
      #3;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge ref_clk);
      #3;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // scoreboard monitor: gap = posedge samples since last tick, high = high half-cycle samples
  int gap_cnt  = 0;
  int high_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge ref_clk);
      #2;
      if (bus.div_tick) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", int'(bus.div_tick), 0);
        end else begin
          e = exp_q.pop_front();
          check("tick_ratio", int'(bus.active_ratio), int'(e.ratio));
          check("tick_upd", int'(bus.ratio_upd), int'(e.upd));
          if (e.gap != 0) begin
            check("period", gap_cnt, int'(e.gap));
            check("high_halves", high_cnt, int'(e.high));
          end
        end
        gap_cnt  = 0;
        high_cnt = 0;
      end else if (bus.ratio_upd) begin
        check("stray_upd", int'(bus.ratio_upd), 0);
      end
      gap_cnt++;
      if (bus.div_clk) high_cnt++;
      @(negedge ref_clk);
      #2;
      if (bus.div_clk) high_cnt++;
    end
  end

  // directed stimulus
  initial begin
    rst           = 1'b0;
    bus.clk_en    = 1'b0;
    bus.div_ratio = W'(4);
    cyc(3);

    check("rst_ratio", int'(bus.active_ratio), 0);
    check("rst_tick", int'(bus.div_tick), 0);
    check("rst_upd", int'(bus.ratio_upd), 0);
    check("rst_clk_hi", int'(bus.div_clk), 1);
    @(negedge ref_clk); #2;
    check("rst_clk_lo", int'(bus.div_clk), 0);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    check("byp_ratio", int'(bus.active_ratio), 4);
    check("byp_clk_hi", int'(bus.div_clk), 1);
    check("byp_tick", int'(bus.div_tick), 0);
    @(negedge ref_clk); #2;
    check("byp_clk_lo", int'(bus.div_clk), 0);
    cyc(1);

    // R=4 start-up and steady periods
    push(4, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(4, 0, 4, exp_high(4));
    bus.clk_en = 1'b1;
    cyc(1);
    check("start_low", int'(bus.div_clk), 0);
    check("start_notick", int'(bus.div_tick), 0);
    cyc(1);
    check("first_rise", int'(bus.div_clk), 1);
    check("first_tick", int'(bus.div_tick), 1);
    drain(20);

    // R=3, adopted after the current R=4 period
    push(3, 1, 4, exp_high(4));
    for (int i = 0; i < 3; i++) push(3, 0, 3, exp_high(3));
    bus.div_ratio = W'(3);
    drain(30);

    // R=6, then write 10 with cnt=3 mid-period
    push(6, 1, 3, exp_high(3));
    push(6, 0, 6, exp_high(6));
    bus.div_ratio = W'(6);
    drain(30);
    cyc(2);
    push(10, 1, 6, exp_high(6));
    push(10, 0, 10, exp_high(10));
    bus.div_ratio = W'(10);
    cyc(1);
    check("hold_ratio", int'(bus.active_ratio), 6);
    drain(40);
    push(10, 0, 10, exp_high(10));
    bus.div_ratio = W'(10);
    drain(20);

    // clk_en drop during the high phase, then re-enable
    bus.clk_en = 1'b0;
    cyc(1);
    check("dis_clk_hi", int'(bus.div_clk), 1);
    @(negedge ref_clk); #2;
    check("dis_clk_lo", int'(bus.div_clk), 0);
    cyc(3);
    check("dis_notick", int'(bus.div_tick), 0);
    push(10, 0, 0, 0);
    push(10, 0, 10, exp_high(10));
    bus.clk_en = 1'b1;
    cyc(1);
    check("re_low", int'(bus.div_clk), 0);
    cyc(1);
    check("re_tick", int'(bus.div_tick), 1);
    drain(30);

    // ratio 1 then 0 -> bypass, active_ratio follows; 7 resumes; max ratio 1023
    push(1, 1, 10, exp_high(10));
    bus.div_ratio = W'(1);
    drain(20);
    check("r1_ratio", int'(bus.active_ratio), 1);
    bus.div_ratio = W'(0);
    @(negedge ref_clk); #2;
    check("r1_clk_lo", int'(bus.div_clk), 0);
    cyc(1);
    check("r0_ratio", int'(bus.active_ratio), 0);
    check("r0_tick", int'(bus.div_tick), 0);
    check("r0_upd", int'(bus.ratio_upd), 0);
    push(7, 0, 0, 0);
    bus.div_ratio = W'(7);
    cyc(1);
    check("r7_follow", int'(bus.active_ratio), 7);
    check("r7_notick", int'(bus.div_tick), 0);
    drain(10);
    push(1023, 1, 7, exp_high(7));
    push(1023, 0, 1023, exp_high(1023));
    bus.div_ratio = W'(1023);
    drain(2200);

    // reset mid-run
    cyc(5);
    rst = 1'b0;
    #1;
    check("mrst_ratio", int'(bus.active_ratio), 0);
    check("mrst_tick", int'(bus.div_tick), 0);
    check("mrst_upd", int'(bus.ratio_upd), 0);
    check("mrst_clk_hi", int'(bus.div_clk), 1);
    @(negedge ref_clk); #2;
    check("mrst_clk_lo", int'(bus.div_clk), 0);
    bus.clk_en = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(3);
    check("post_ratio", int'(bus.active_ratio), 1023);
    check("post_tick", int'(bus.div_tick), 0);
    check("post_clk_hi", int'(bus.div_clk), 1);
    @(negedge ref_clk); #2;
    check("post_clk_lo", int'(bus.div_clk), 0);
    cyc(1);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
